dfx_seq_engine: RTL and testbench
=================================

Name: dfx_seq_engine

Overview:
- Sequencer core that walks the bank1 slot table from the bank0 start index to the bank0 end index.
- For each valid slot it fetches the descriptor, issues one DMA command, and times the transfer. It then writes the slot status and profile cycle count back to bank1.
- It drives the bank0 status field that software polls through the AXI-lite read slave.

Parameters:
BANK1_INDEX_WIDTH, 3, slot index width (2^W slots)
BANK1_SRC_ADDR_WIDTH, 32, source address width
BANK1_SRC_SIZE_WIDTH, 26, source size width
BANK1_DST_ADDR_WIDTH, 32, destination address width
BANK1_DST_SIZE_WIDTH, 26, destination size width
BANK1_STATUS_WIDTH, 2, slot status width
BANK1_PROFILE_WIDTH, 32, profile counter width
BANK0_STATUS_WIDTH, 4, engine status width
BANK0_CNT_WIDTH, BANK1_INDEX_WIDTH, sequence counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ctrl_start  in  1  one-cycle start pulse from bank0 control
ctrl_stop  in  1  one-cycle stop-request pulse
cfg_mainCnt  in  BANK0_CNT_WIDTH  first slot index
cfg_endCnt  in  BANK0_CNT_WIDTH  last slot index (inclusive)
bank1_rd_index  out  BANK1_INDEX_WIDTH  slot being fetched
bank1_rd_req  out  1  fetch request
bank1_rd_ready  in  1  fetch data valid
bank1_rd_src_addr  in  BANK1_SRC_ADDR_WIDTH  slot source address
bank1_rd_src_size  in  BANK1_SRC_SIZE_WIDTH  slot source size
bank1_rd_des_addr  in  BANK1_DST_ADDR_WIDTH  slot destination address
bank1_rd_des_size  in  BANK1_DST_SIZE_WIDTH  slot destination size
bank1_rd_status  in  BANK1_STATUS_WIDTH  slot status
bank1_wr_index  out  BANK1_INDEX_WIDTH  slot being written back
bank1_wr_en  out  1  one-cycle write-back strobe
bank1_wr_status  out  BANK1_STATUS_WIDTH  new slot status
bank1_wr_profile  out  BANK1_PROFILE_WIDTH  measured cycle count
dma_cmd_valid  out  1  DMA command valid
dma_cmd_ready  in  1  DMA command accept
dma_src_addr, dma_src_size, dma_des_addr, dma_des_size  out  slot widths  latched descriptor
dma_done  in  1  transfer-complete pulse
dma_err  in  1  transfer-error pulse
seq_status  out  BANK0_STATUS_WIDTH  {aborted, error, done, busy}
seq_curCnt  out  BANK0_CNT_WIDTH  current slot index

Behaviour:
Reset values:
- All outputs are 0. State is IDLE.
- Reset mid-operation returns the block to IDLE on the next edge. No write-back is issued and dma_cmd_valid drops.

Slot status encoding: 00 empty (skip), 01 pending, 10 done, 11 error.

States:
- IDLE: on ctrl_start, load cnt <= cfg_mainCnt, clear seq_status[3:1], set busy, go to FETCH. ctrl_start is ignored in every other state.
- FETCH:
  - bank1_rd_req=1, bank1_rd_index=cnt; hold until bank1_rd_ready.
  - On ready, latch the descriptor and status.
  - Status 00 -> go to NEXT with no write-back.
  - Status 10 or 11 -> go to NEXT (already processed, skipped).
  - Status 01 -> go to ISSUE.
- ISSUE:
  - dma_cmd_valid=1 with the latched descriptor. Fields stay stable until dma_cmd_ready.
  - Clear the profile counter and go to WAIT on the accept cycle.
- WAIT:
  - The profile counter increments every cycle, starting at 1 in the first WAIT cycle, and saturates at all-ones.
  - dma_done -> wr_status=10.
  - dma_err, or dma_done and dma_err in the same cycle -> wr_status=11 and set error.
  - Go to WRITEBACK.
- WRITEBACK: bank1_wr_en=1 for exactly one cycle with wr_index=cnt and profile=count. If error is set, go to DONE; otherwise go to NEXT.
- NEXT:
  - Abort pending -> go to DONE with aborted set.
  - cnt==cfg_endCnt -> go to DONE.
  - Otherwise cnt <= cnt+1 modulo 2^W and go to FETCH.
  - If cfg_endCnt < cfg_mainCnt, the walk wraps through the highest index to 0.
  - If main==end, exactly one slot is processed.
- DONE: clear busy, set done, go to IDLE. done, error and aborted are sticky until the next start.

Stop handling:
- ctrl_stop sets an abort-pending flag, acted on only in NEXT. An in-flight DMA is never cancelled.
- ctrl_stop in IDLE is ignored.

Outputs:
- seq_curCnt always reflects cnt.
- Latency from ctrl_start to the first bank1_rd_req is 1 cycle.

Test Plan:
- Start with main=0, end=2, all slots status 01, DMA ready immediate, done after 5 cycles -> 3 write-backs with status 10 and profile 5 each; seq_status ends 4'b0010.
- Start with main=6, end=1 (W=3), slot 7 status 00 -> fetches 6,7,0,1 in order; only 6,0,1 issue DMA; no write-back for 7.
- Slot 1 gets dma_err -> write-back status 11, no fetch of slot 2, seq_status=4'b0110.
- ctrl_stop pulsed during WAIT on slot 0 (main=0, end=3) -> slot 0 completes and is written back; engine stops; seq_status=4'b1010, seq_curCnt=0.
- dma_cmd_ready held low 10 cycles -> dma_cmd_valid and descriptor fields are stable throughout; profile counts only after accept.
- Reset asserted in WAIT -> next cycle all outputs 0, state IDLE; a new start runs normally.

Source files
------------

// File: rtl/dfx_seq_engine.sv
// Sequencer core: walks bank1 slots from cfg_mainCnt to cfg_endCnt, issues one DMA per
// pending slot, times it, and writes status/profile back. Reports progress via seq_status.
module dfx_seq_engine #(
  parameter int unsigned BANK1_INDEX_WIDTH    = 3,
  parameter int unsigned BANK1_SRC_ADDR_WIDTH = 32,
  parameter int unsigned BANK1_SRC_SIZE_WIDTH = 26,
  parameter int unsigned BANK1_DST_ADDR_WIDTH = 32,
  parameter int unsigned BANK1_DST_SIZE_WIDTH = 26,
  parameter int unsigned BANK1_STATUS_WIDTH   = 2,
  parameter int unsigned BANK1_PROFILE_WIDTH  = 32,
  parameter int unsigned BANK0_STATUS_WIDTH   = 4,
  parameter int unsigned BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ctrl_start,
  input  logic                            ctrl_stop,
  input  logic [BANK0_CNT_WIDTH-1:0]      cfg_mainCnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      cfg_endCnt,
  output logic [BANK1_INDEX_WIDTH-1:0]    bank1_rd_index,
  output logic                            bank1_rd_req,
  input  logic                            bank1_rd_ready,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] bank1_rd_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] bank1_rd_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] bank1_rd_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] bank1_rd_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   bank1_rd_status,
  output logic [BANK1_INDEX_WIDTH-1:0]    bank1_wr_index,
  output logic                            bank1_wr_en,
  output logic [BANK1_STATUS_WIDTH-1:0]   bank1_wr_status,
  output logic [BANK1_PROFILE_WIDTH-1:0]  bank1_wr_profile,
  output logic                            dma_cmd_valid,
  input  logic                            dma_cmd_ready,
  output logic [BANK1_SRC_ADDR_WIDTH-1:0] dma_src_addr,
  output logic [BANK1_SRC_SIZE_WIDTH-1:0] dma_src_size,
  output logic [BANK1_DST_ADDR_WIDTH-1:0] dma_des_addr,
  output logic [BANK1_DST_SIZE_WIDTH-1:0] dma_des_size,
  input  logic                            dma_done,
  input  logic                            dma_err,
  output logic [BANK0_STATUS_WIDTH-1:0]   seq_status,
  output logic [BANK0_CNT_WIDTH-1:0]      seq_curCnt
);

  localparam logic [BANK1_STATUS_WIDTH-1:0] SLOT_PENDING = BANK1_STATUS_WIDTH'(2'b01);
  localparam logic [BANK1_STATUS_WIDTH-1:0] SLOT_DONE    = BANK1_STATUS_WIDTH'(2'b10);
  localparam logic [BANK1_STATUS_WIDTH-1:0] SLOT_ERROR   = BANK1_STATUS_WIDTH'(2'b11);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITEBACK, S_NEXT, S_DONE
  } state_t;

  state_t                          state, state_nxt;
  logic [BANK0_CNT_WIDTH-1:0]      cnt;
  logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr_q;
  logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size_q;
  logic [BANK1_DST_ADDR_WIDTH-1:0] des_addr_q;
  logic [BANK1_DST_SIZE_WIDTH-1:0] des_size_q;
  logic [BANK1_PROFILE_WIDTH-1:0]  profile_q;
  logic [BANK1_STATUS_WIDTH-1:0]   wr_status_q;
  logic                            busy_q, done_q, error_q, aborted_q, abort_pend_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (ctrl_start) state_nxt = S_FETCH;
      S_FETCH:     if (bank1_rd_ready)
                     state_nxt = (bank1_rd_status == SLOT_PENDING) ? S_ISSUE : S_NEXT;
      S_ISSUE:     if (dma_cmd_ready) state_nxt = S_WAIT;
      S_WAIT:      if (dma_done || dma_err) state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = error_q ? S_DONE : S_NEXT;
      S_NEXT:      state_nxt = (abort_pend_q || (cnt == cfg_endCnt)) ? S_DONE : S_FETCH;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Slot counter, latched descriptor, profile timer and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      src_addr_q   <= '0;
      src_size_q   <= '0;
      des_addr_q   <= '0;
      des_size_q   <= '0;
      profile_q    <= '0;
      wr_status_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (state != S_IDLE && ctrl_stop) abort_pend_q <= 1'b1;
      case (state)
        S_IDLE: if (ctrl_start) begin
          cnt          <= cfg_mainCnt;
          busy_q       <= 1'b1;
          done_q       <= 1'b0;
          error_q      <= 1'b0;
          aborted_q    <= 1'b0;
          abort_pend_q <= 1'b0;
        end
        S_FETCH: if (bank1_rd_ready) begin
          src_addr_q <= bank1_rd_src_addr;
          src_size_q <= bank1_rd_src_size;
          des_addr_q <= bank1_rd_des_addr;
          des_size_q <= bank1_rd_des_size;
        end
        S_ISSUE: if (dma_cmd_ready) profile_q <= '0;
        S_WAIT: begin
          if (!(&profile_q)) profile_q <= profile_q + BANK1_PROFILE_WIDTH'(1);
          if (dma_err) begin
            wr_status_q <= SLOT_ERROR;
            error_q     <= 1'b1;
          end else if (dma_done) begin
            wr_status_q <= SLOT_DONE;
          end
        end
        S_NEXT: begin
          if (abort_pend_q)            aborted_q <= 1'b1;
          else if (cnt != cfg_endCnt)  cnt       <= cnt + BANK0_CNT_WIDTH'(1);
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from registered state and datapath only.
  always_comb begin
    bank1_rd_req     = 1'b0;
    bank1_rd_index   = '0;
    dma_cmd_valid    = 1'b0;
    dma_src_addr     = '0;
    dma_src_size     = '0;
    dma_des_addr     = '0;
    dma_des_size     = '0;
    bank1_wr_en      = 1'b0;
    bank1_wr_index   = '0;
    bank1_wr_status  = '0;
    bank1_wr_profile = '0;
    seq_status       = BANK0_STATUS_WIDTH'({aborted_q, error_q, done_q, busy_q});
    seq_curCnt       = cnt;
    case (state)
      S_FETCH: begin
        bank1_rd_req   = 1'b1;
        bank1_rd_index = BANK1_INDEX_WIDTH'(cnt);
      end
      S_ISSUE: begin
        dma_cmd_valid = 1'b1;
        dma_src_addr  = src_addr_q;
        dma_src_size  = src_size_q;
        dma_des_addr  = des_addr_q;
        dma_des_size  = des_size_q;
      end
      S_WRITEBACK: begin
        bank1_wr_en      = 1'b1;
        bank1_wr_index   = BANK1_INDEX_WIDTH'(cnt);
        bank1_wr_status  = wr_status_q;
        bank1_wr_profile = profile_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dfx_seq_engine.sv
// Self-checking bench for dfx_seq_engine: bank1 table and DMA responders, a slot-walk
// reference model, a table of directed scenarios, hand-written corner sequences and random runs.
module tb_dfx_seq_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_start, ctrl_stop;
  logic [2:0]  cfg_mainCnt, cfg_endCnt;
  logic [2:0]  bank1_rd_index, bank1_wr_index;
  logic        bank1_rd_req, bank1_rd_ready, bank1_wr_en;
  logic [31:0] bank1_rd_src_addr, bank1_rd_des_addr;
  logic [25:0] bank1_rd_src_size, bank1_rd_des_size;
  logic [1:0]  bank1_rd_status, bank1_wr_status;
  logic [31:0] bank1_wr_profile;
  logic        dma_cmd_valid, dma_cmd_ready, dma_done, dma_err;
  logic [31:0] dma_src_addr, dma_des_addr;
  logic [25:0] dma_src_size, dma_des_size;
  logic [3:0]  seq_status;
  logic [2:0]  seq_curCnt;

  dfx_seq_engine dut (
    .clk(clk), .reset(reset), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .cfg_mainCnt(cfg_mainCnt), .cfg_endCnt(cfg_endCnt),
    .bank1_rd_index(bank1_rd_index), .bank1_rd_req(bank1_rd_req), .bank1_rd_ready(bank1_rd_ready),
    .bank1_rd_src_addr(bank1_rd_src_addr), .bank1_rd_src_size(bank1_rd_src_size),
    .bank1_rd_des_addr(bank1_rd_des_addr), .bank1_rd_des_size(bank1_rd_des_size),
    .bank1_rd_status(bank1_rd_status),
    .bank1_wr_index(bank1_wr_index), .bank1_wr_en(bank1_wr_en),
    .bank1_wr_status(bank1_wr_status), .bank1_wr_profile(bank1_wr_profile),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_src_addr(dma_src_addr), .dma_src_size(dma_src_size),
    .dma_des_addr(dma_des_addr), .dma_des_size(dma_des_size),
    .dma_done(dma_done), .dma_err(dma_err),
    .seq_status(seq_status), .seq_curCnt(seq_curCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  idx;
    logic [1:0]  st;
    logic [31:0] prof;
  } wb_t;

  typedef struct {
    int mn, en;
    logic [15:0] st;
    logic [7:0] err, both;
    int lat, cdly, rdly;
    logic [3:0] xst;
    int xcur, xnf, xnwb;
  } vec_t;

  // Bank1 table contents and per-slot DMA behaviour
  logic [1:0]  mem_st [8];
  logic [31:0] src_a [8], des_a [8];
  logic [25:0] src_s [8], des_s [8];
  int          lat [8];
  bit          err_f [8], both_f [8];
  int          rd_dly, cmd_dly, stop_slot_g;

  int rd_cnt, cmd_cnt, wait_cnt, last_fetch;
  bit in_wait;
  int fetch_q[$], issue_q[$], exp_fetch[$], exp_issue[$];
  wb_t wb_q[$], exp_wb[$];
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives bank1 read data and DMA handshakes for the current cycle and logs DUT activity.
  task automatic respond();
    int idx;
    bank1_rd_ready = 1'b0; bank1_rd_status = '0;
    bank1_rd_src_addr = '0; bank1_rd_src_size = '0;
    bank1_rd_des_addr = '0; bank1_rd_des_size = '0;
    dma_cmd_ready = 1'b0; dma_done = 1'b0; dma_err = 1'b0;
    if (bank1_rd_req) begin
      if (rd_cnt >= rd_dly) begin
        idx = int'(bank1_rd_index);
        bank1_rd_ready = 1'b1;
        bank1_rd_status = mem_st[idx];
        bank1_rd_src_addr = src_a[idx]; bank1_rd_src_size = src_s[idx];
        bank1_rd_des_addr = des_a[idx]; bank1_rd_des_size = des_s[idx];
        fetch_q.push_back(idx);
        last_fetch = idx;
        rd_cnt = 0;
      end else rd_cnt++;
    end
    if (dma_cmd_valid) begin
      check("dma_desc", {dma_src_addr, dma_src_size, dma_des_addr, dma_des_size},
            {src_a[last_fetch], src_s[last_fetch], des_a[last_fetch], des_s[last_fetch]});
      if (cmd_cnt >= cmd_dly) begin
        dma_cmd_ready = 1'b1;
        issue_q.push_back(last_fetch);
        cmd_cnt = 0; in_wait = 1'b1; wait_cnt = 0;
      end else cmd_cnt++;
    end else if (in_wait) begin
      wait_cnt++;
      if (wait_cnt == 1 && last_fetch == stop_slot_g) ctrl_stop = 1'b1;
      if (wait_cnt >= lat[last_fetch]) begin
        dma_err  = err_f[last_fetch];
        dma_done = !err_f[last_fetch] || both_f[last_fetch];
        in_wait  = 1'b0;
      end
    end
    if (bank1_wr_en) begin
      wb_q.push_back({bank1_wr_index, bank1_wr_status, bank1_wr_profile});
      mem_st[int'(bank1_wr_index)] = bank1_wr_status;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
    @(posedge clk);
    #1;
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
  endtask

  // Reference: walk slots main..end (wrapping), one DMA per pending slot.
  task automatic model(input int m, input int e, input int stop_slot,
                       output logic [3:0] xst, output int xcur);
    int i;
    exp_fetch.delete(); exp_issue.delete(); exp_wb.delete();
    i = m;
    for (int n = 0; n < 8; n++) begin
      exp_fetch.push_back(i);
      if (mem_st[i] == 2'b01) begin
        exp_issue.push_back(i);
        exp_wb.push_back({3'(i), (err_f[i] ? 2'b11 : 2'b10), 32'(lat[i])});
        if (err_f[i])      begin xst = 4'b0110; xcur = i; return; end
        if (i == stop_slot) begin xst = 4'b1010; xcur = i; return; end
      end
      if (i == e) begin xst = 4'b0010; xcur = i; return; end
      i = (i + 1) % 8;
    end
    xst = 4'bxxxx; xcur = -1;
  endtask

  task automatic run_case(input int m, input int e, input int stop_slot,
                          output logic [3:0] fst, output int fcur, output int nf, output int nwb);
    logic [3:0] xst;
    int xcur, cyc;
    model(m, e, stop_slot, xst, xcur);
    fetch_q.delete(); issue_q.delete(); wb_q.delete();
    rd_cnt = 0; cmd_cnt = 0; in_wait = 1'b0; stop_slot_g = stop_slot;
    cfg_mainCnt = 3'(m); cfg_endCnt = 3'(e);
    ctrl_start = 1'b1;
    tick();
    check("start_to_rd_req", bank1_rd_req, 1'b1);
    cyc = 0;
    while (!seq_status[1] && cyc < 2000) begin tick(); cyc++; end
    check("run_timeout", cyc < 2000, 1'b1);
    check("fetch_count", fetch_q.size(), exp_fetch.size());
    for (int k = 0; k < exp_fetch.size(); k++)
      check("fetch_order", k < fetch_q.size() ? fetch_q[k] : 99, exp_fetch[k]);
    check("issue_count", issue_q.size(), exp_issue.size());
    for (int k = 0; k < exp_issue.size(); k++)
      check("issue_order", k < issue_q.size() ? issue_q[k] : 99, exp_issue[k]);
    check("wb_count", wb_q.size(), exp_wb.size());
    for (int k = 0; k < exp_wb.size(); k++)
      check("wb_record", k < wb_q.size() ? wb_q[k] : '1, exp_wb[k]);
    check("final_status", seq_status, xst);
    check("final_curcnt", seq_curCnt, xcur);
    fst = seq_status; fcur = int'(seq_curCnt); nf = fetch_q.size(); nwb = wb_q.size();
  endtask

  task automatic rand_desc();
    for (int i = 0; i < 8; i++) begin
      src_a[i] = $urandom; des_a[i] = $urandom;
      src_s[i] = 26'($urandom); des_s[i] = 26'($urandom);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_req"}, bank1_rd_req, 1'b0);
    check({tag, "_rd_index"}, bank1_rd_index, 3'd0);
    check({tag, "_wr_en"}, bank1_wr_en, 1'b0);
    check({tag, "_wr_fields"}, {bank1_wr_index, bank1_wr_status, bank1_wr_profile}, '0);
    check({tag, "_cmd_valid"}, dma_cmd_valid, 1'b0);
    check({tag, "_dma_fields"}, {dma_src_addr, dma_src_size, dma_des_addr, dma_des_size}, '0);
    check({tag, "_seq_status"}, seq_status, 4'b0000);
    check({tag, "_curcnt"}, seq_curCnt, 3'd0);
  endtask

  initial begin
    vec_t vecs [7];
    vec_t v;
    logic [3:0] fst;
    int fcur, nf, nwb, cyc;

    vecs[0] = '{0, 2, 16'h5555, 8'h00, 8'h00, 5, 0, 0, 4'b0010, 2, 3, 3};
    vecs[1] = '{6, 1, 16'h1555, 8'h00, 8'h00, 3, 1, 1, 4'b0010, 1, 4, 3};
    vecs[2] = '{0, 3, 16'h5555, 8'h02, 8'h00, 3, 0, 0, 4'b0110, 1, 2, 2};
    vecs[3] = '{3, 3, 16'h5555, 8'h00, 8'h00, 4, 10, 2, 4'b0010, 3, 1, 1};
    vecs[4] = '{2, 5, 16'h04E0, 8'h00, 8'h00, 2, 0, 1, 4'b0010, 5, 4, 1};
    vecs[5] = '{0, 7, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 4'b0010, 7, 8, 0};
    vecs[6] = '{4, 6, 16'h5555, 8'h20, 8'h20, 1, 2, 0, 4'b0110, 5, 2, 2};

    reset = 1'b1; ctrl_start = 1'b0; ctrl_stop = 1'b0;
    cfg_mainCnt = '0; cfg_endCnt = '0; stop_slot_g = -1;
    rd_dly = 0; cmd_dly = 0; in_wait = 1'b0; rd_cnt = 0; cmd_cnt = 0; last_fetch = 0;
    for (int i = 0; i < 8; i++) begin mem_st[i] = 2'b00; lat[i] = 1; err_f[i] = 0; both_f[i] = 0; end
    rand_desc();
    repeat (3) tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();
    check_idle_zero("post_reset");

    // A stop while idle must not mark the next run as aborted
    ctrl_stop = 1'b1;
    tick();
    check("idle_stop_status", seq_status, 4'b0000);

    for (int n = 0; n < 7; n++) begin
      v = vecs[n];
      for (int i = 0; i < 8; i++) begin
        mem_st[i] = v.st[2*i +: 2];
        err_f[i] = v.err[i]; both_f[i] = v.both[i]; lat[i] = v.lat;
      end
      rand_desc();
      cmd_dly = v.cdly; rd_dly = v.rdly;
      run_case(v.mn, v.en, -1, fst, fcur, nf, nwb);
      check("vec_status", fst, v.xst);
      check("vec_curcnt", fcur, v.xcur);
      check("vec_nfetch", nf, v.xnf);
      check("vec_nwb", nwb, v.xnwb);
      repeat (2) tick();
    end

    // Stop requested during slot 0 transfer: slot finishes, walk ends aborted
    for (int i = 0; i < 8; i++) begin mem_st[i] = 2'b01; lat[i] = 4; err_f[i] = 0; both_f[i] = 0; end
    cmd_dly = 0; rd_dly = 0;
    run_case(0, 3, 0, fst, fcur, nf, nwb);
    check("stop_status", fst, 4'b1010);
    check("stop_curcnt", fcur, 0);
    check("stop_nwb", nwb, 1);
    repeat (2) tick();

    // Reset asserted while waiting on the DMA
    for (int i = 0; i < 8; i++) begin mem_st[i] = 2'b01; lat[i] = 20; end
    fetch_q.delete(); issue_q.delete(); wb_q.delete();
    stop_slot_g = -1; rd_cnt = 0; cmd_cnt = 0; in_wait = 1'b0;
    cfg_mainCnt = 3'd0; cfg_endCnt = 3'd1;
    ctrl_start = 1'b1;
    tick();
    cyc = 0;
    while (!(in_wait && wait_cnt >= 3) && cyc < 100) begin tick(); cyc++; end
    check("reached_wait", in_wait, 1'b1);
    reset = 1'b1;
    tick();
    check_idle_zero("wait_reset");
    reset = 1'b0; in_wait = 1'b0; rd_cnt = 0; cmd_cnt = 0;
    repeat (3) tick();
    check("no_wb_after_reset", wb_q.size(), 0);
    check("idle_after_reset", bank1_rd_req, 1'b0);
    for (int i = 0; i < 8; i++) lat[i] = 3;
    run_case(0, 1, -1, fst, fcur, nf, nwb);
    check("restart_status", fst, 4'b0010);
    repeat (2) tick();

    // Randomised walks against the reference model
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) begin
        mem_st[i] = 2'($urandom_range(0, 3));
        lat[i] = $urandom_range(1, 8);
        err_f[i] = ($urandom_range(0, 5) == 0);
        both_f[i] = $urandom_range(0, 1);
      end
      rand_desc();
      cmd_dly = $urandom_range(0, 3); rd_dly = $urandom_range(0, 2);
      run_case($urandom_range(0, 7), $urandom_range(0, 7), -1, fst, fcur, nf, nwb);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
